// File: rtl/conv_pkg.sv
// conv_pkg: shared constants for the vertical 7-tap column convolution.
//   LINE_W_DEF / ROWS_DEF : default frame geometry (valid pixels per row, rows)
//   SUM_W                 : signed width of the vertical sum
//   K0_DEF..K6_DEF        : default vertical coefficients, K0 = oldest row
//   tap()                 : one coefficient times one zero-extended pixel
package conv_pkg;

    localparam int LINE_W_DEF = 214;
    localparam int ROWS_DEF   = 220;
    localparam int SUM_W      = 16;
    localparam int NTAPS      = 7;
    localparam int NBUF       = NTAPS - 1;

    localparam int K0_DEF = -1;
    localparam int K1_DEF = 0;
    localparam int K2_DEF = 1;
    localparam int K3_DEF = 0;
    localparam int K4_DEF = -1;
    localparam int K5_DEF = 0;
    localparam int K6_DEF = 1;

    function automatic logic signed [SUM_W-1:0] tap(input int k, input logic [7:0] p);
        logic signed [SUM_W-1:0] kk;
        logic signed [SUM_W-1:0] pp;
        kk = SUM_W'(k);
        pp = $signed({{(SUM_W-8){1'b0}}, p});
        return kk * pp;
    endfunction

endpackage

// File: rtl/line_buf6.sv
// line_buf6: ring of six LINE_W x 8 line buffers addressed by column.
//   clk    : clock
//   we     : write the incoming pixel into the oldest buffer at addr
//   oldest : index of the buffer holding the oldest row (r-6)
//   addr   : column address shared by the write and all six reads
//   wdata  : pixel to store
//   rdata  : six reads at addr, rdata[0] = row r-6 ... rdata[5] = row r-1
// Reads are combinational from the array, so a same-address write in the
// same cycle is only visible afterwards (old data is returned).
module line_buf6 #(
    parameter int LINE_W = 214,
    parameter int AW     = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [2:0]       oldest,
    input  logic [AW-1:0]    addr,
    input  logic [7:0]       wdata,
    output logic [5:0][7:0]  rdata
);

    logic [7:0] mem [6][LINE_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[oldest][addr] <= wdata;
        end
    end

    // Rotate the physical buffers so that rdata is ordered oldest first.
    always_comb begin
        logic [3:0] sel;
        rdata = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            sel = {1'b0, oldest} + 4'(i);
            if (sel >= 4'd6) begin
                sel = sel - 4'd6;
            end
            rdata[i] = mem[sel[2:0]][addr];
        end
    end

endmodule

// File: rtl/conv_col7.sv
// conv_col7: vertical 7x1 convolution behind a horizontal 1x7 stage.
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   pxl_in     : unsigned pixel, valid when valid_in is high
//   valid_in   : accept pxl_in this cycle
//   pxl_out    : |sum| saturated to 255, held between valid outputs
//   valid_out  : pxl_out valid; two cycles after an accepted pixel of row >= 6
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
module conv_col7 import conv_pkg::*; #(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int K0     = K0_DEF,
    parameter int K1     = K1_DEF,
    parameter int K2     = K2_DEF,
    parameter int K3     = K3_DEF,
    parameter int K4     = K4_DEF,
    parameter int K5     = K5_DEF,
    parameter int K6     = K6_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pxl_in,
    input  logic       valid_in,
    output logic [7:0] pxl_out,
    output logic       valid_out,
    output logic       frame_done
);

    localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int K [NTAPS] = '{K0, K1, K2, K3, K4, K5, K6};

    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [2:0]              oldest;
    logic [5:0][7:0]         taps;
    logic signed [SUM_W-1:0] prod [NTAPS];
    logic                    v1;
    logic signed [SUM_W-1:0] sum;
    logic [SUM_W:0]          mag;
    logic [7:0]              sat;
    logic                    col_last;
    logic                    row_last;

    assign col_last = (col == CW'(LINE_W - 1));
    assign row_last = (row == RW'(ROWS - 1));

    line_buf6 #(
        .LINE_W (LINE_W),
        .AW     (CW)
    ) u_buf (
        .clk    (clk),
        .we     (valid_in),
        .oldest (oldest),
        .addr   (col),
        .wdata  (pxl_in),
        .rdata  (taps)
    );

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            oldest     <= '0;
            v1         <= 1'b0;
            valid_out  <= 1'b0;
            pxl_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= valid_in && col_last && row_last;
            v1         <= valid_in && (int'(row) >= NBUF);
            valid_out  <= v1;
            if (v1) begin
                pxl_out <= sat;
            end
            if (valid_in) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                    // The buffer just overwritten now holds the newest row,
                    // so the next oldest row lives one slot further on.
                    oldest <= (oldest == 3'd5) ? '0 : oldest + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Stage 1: buffer read and products; zero coefficients are forced to 0.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NTAPS; i++) begin
            if (K[i] == 0) begin
                prod[i] <= '0;
            end else if (i < NBUF) begin
                prod[i] <= tap(K[i], taps[i]);
            end else begin
                prod[i] <= tap(K[i], pxl_in);
            end
        end
    end

    // Stage 2: sum, absolute value (one extra bit so -32768 is safe), saturate.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            sum = sum + prod[i];
        end
        mag = sum[SUM_W-1] ? (SUM_W+1)'(-{sum[SUM_W-1], sum}) : (SUM_W+1)'({1'b0, sum});
        sat = (mag > (SUM_W+1)'(255)) ? 8'hFF : mag[7:0];
    end

endmodule

// File: tb/tb_conv_col7.sv
// tb_conv_col7: scoreboard bench for conv_col7 with a 4x8 frame.
module tb_conv_col7;

    localparam int LW = 4;
    localparam int RS = 8;
    localparam int KC [7] = '{-1, 0, 1, 0, -1, 0, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pxl_in = '0;
    logic       valid_in = 1'b0;
    logic [7:0] pxl_out;
    logic       valid_out;
    logic       frame_done;

    conv_col7 #(
        .LINE_W (LW),
        .ROWS   (RS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pxl_in     (pxl_in),
        .valid_in   (valid_in),
        .pxl_out    (pxl_out),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pxl;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   img [RS][LW];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fd_due = -1;
    int   last_out = 0;
    int   valid_cnt = 0;
    int   fd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int exp_at(input int r, input int c);
        int s;
        s = 0;
        for (int i = 0; i < 7; i++) s += KC[i] * img[r - 6 + i][c];
        if (s < 0) s = -s;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int pix(input int mode, input int r);
        case (mode)
            0:       return 100;
            1:       return 10 * r;
            2:       return (r == 2 || r == 6) ? 255 : 0;
            3:       return (r == 0 || r == 4) ? 100 : 0;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_out) begin
                valid_cnt++;
                if (q.size() == 0) begin
                    check("spurious_valid", int'(valid_out), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("pxl", int'(pxl_out), e.pxl);
                    check("latency", cyc, e.cyc);
                    last_out = e.pxl;
                end
            end else begin
                check("hold", int'(pxl_out), last_out);
            end
            if (frame_done) fd_cnt++;
            if (cyc == fd_due) check("frame_done", int'(frame_done), 1);
            else if (frame_done) check("fd_spurious", int'(frame_done), 0);
        end
    end

    task automatic gap(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_pix(input int r, input int c, input int p);
        img[r][c] = p;
        if (r >= 6) q.push_back('{exp_at(r, c), cyc + 2});
        if (r == RS - 1 && c == LW - 1) fd_due = cyc + 1;
        pxl_in   = 8'(p);
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Drives a frame, stopping just before (stop_r, stop_c) when stop_r >= 0.
    task automatic drive_frame(input int mode, input int stop_r, input int stop_c);
        for (int r = 0; r < RS; r++) begin
            for (int c = 0; c < LW; c++) begin
                if (r == stop_r && c == stop_c) return;
                drive_pix(r, c, pix(mode, r));
                if (mode == 1 && r == 6 && c == 0) gap(2);
                if (mode == 4 && $urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 3)));
            end
        end
    endtask

    task automatic end_frame();
        gap(4);
        check("drain", q.size(), 0);
        check("valid_cnt", valid_cnt, LW * (RS - 6));
        check("fd_cnt", fd_cnt, 1);
        valid_cnt = 0;
        fd_cnt    = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_pxl", int'(pxl_out), 0);
        check("rst_valid", int'(valid_out), 0);
        check("rst_fd", int'(frame_done), 0);
        reset = 1'b0;
        gap(2);

        drive_frame(0, -1, 0);
        end_frame();
        drive_frame(1, -1, 0);
        end_frame();
        drive_frame(2, -1, 0);
        end_frame();
        drive_frame(3, -1, 0);
        end_frame();
        drive_frame(4, -1, 0);
        end_frame();

        // Mid-frame reset at row 7, col 2, then a fresh random frame.
        drive_frame(4, 7, 2);
        reset = 1'b1;
        q.delete();
        fd_due    = -1;
        last_out  = 0;
        valid_cnt = 0;
        fd_cnt    = 0;
        #1;
        check("mid_rst_pxl", int'(pxl_out), 0);
        check("mid_rst_valid", int'(valid_out), 0);
        check("mid_rst_fd", int'(frame_done), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        gap(1);
        drive_frame(4, -1, 0);
        end_frame();
        drive_frame(1, -1, 0);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/conv_col7.md
CONV_COL7 -- requirements
Module: conv_col7

Interface
REQ-001 Parameter LINE_W, default 214, meaning valid pixels per row delivered by the horizontal 1x7 stage.
REQ-002 Parameter ROWS, default 220, meaning rows per frame.
REQ-003 Parameter K0..K6, default -1,0,1,0,-1,0,1, meaning signed vertical coefficients; K0 applies to the oldest row (r-6) and K6 to the current row r.
REQ-004 clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  meaning asynchronous, active-high reset.
REQ-006 pxl_in  input  8  meaning unsigned pixel from the horizontal stage output.
REQ-007 valid_in  input  1  meaning pxl_in is a valid sample this cycle.
REQ-008 pxl_out  output  8  meaning saturated absolute value of the vertical sum.
REQ-009 valid_out  output  1  meaning pxl_out is valid this cycle.
REQ-010 frame_done  output  1  meaning a one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-011 The block SHALL keep the col counter (0..LINE_W-1) and row counter (0..ROWS-1), and SHALL advance them only on cycles with valid_in=1.
REQ-012 When col=LINE_W-1, the block SHALL wrap col to 0 and increment row; when row=ROWS-1 at the same time, it SHALL wrap row to 0 and pulse frame_done in the next cycle.
REQ-013 The block SHALL hold six line buffers of LINE_W x 8 bit in a ring, giving the samples at the same col for rows r-6..r-1; each accepted pixel SHALL overwrite the oldest row's entry at col.
REQ-014 Sum SHALL be signed 16 bit: sum = Σ Ki * zero-extended pixel(row r-6+i, col); coefficients with value 0 SHALL contribute nothing.
REQ-015 pxl_out SHALL be |sum| saturated to 255 (no truncation of bits above 7).
REQ-016 valid_out SHALL be asserted exactly two cycles after an accepted valid_in when that pixel's row is >=6, and SHALL be 0 otherwise.
REQ-017 Latency SHALL be fixed at 2 cycles from accepted input to output: stage 1 does the buffer read and the products, stage 2 does the sum, abs and saturate. The pipeline SHALL advance every cycle, so a valid_in gap produces a valid_out gap of the same length two cycles later.
REQ-018 Each frame SHALL produce exactly LINE_W*(ROWS-6) valid_out pulses.
REQ-019 A read and a write to the same buffer address in one cycle SHALL return the old (pre-write) data.
REQ-020 When valid_in=0, pxl_out SHALL hold its last value.

Reset
REQ-021 On reset, col, row, the pipeline valid flags, pxl_out, valid_out and frame_done SHALL all go to 0 immediately (asynchronous reset).
REQ-022 Line buffer contents SHALL NOT be reset; the row<6 suppression SHALL guarantee that no stale data reaches a valid output.
REQ-023 A reset in the middle of a frame SHALL restart counting, and the next accepted pixel SHALL be treated as row 0, col 0.

Structure
REQ-024 The kernel coefficient constants, the default LINE_W/ROWS and the sum width (16) SHALL live in the shared package conv_pkg.
REQ-025 The line-buffer ring SHALL be a sub-module named line_buf6 (one write port, six read outputs, addressed by col).

Verification
REQ-026 LINE_W=4, ROWS=8, constant pixel 100 -> 8 valid_out pulses, each pxl_out=0, and one frame_done.
REQ-027 LINE_W=4, ROWS=8, pixel=10*row -> the first valid output (row 6, col 0) is pxl_out=40, and no valid_out appears for rows 0-5.
REQ-028 Rows 2 and 6 at 255, all others 0 -> sum=510 -> pxl_out=255 (saturated); rows 0 and 4 at 100, others 0 -> sum=-200 -> pxl_out=200.
REQ-029 valid_in toggling 1,0,0,1 during row 6 -> valid_out pattern 1,0,0,1 delayed by exactly two cycles, with correct values.
REQ-030 Reset asserted at row 7, col 2, then a fresh frame -> outputs are suppressed until the new row 6, and the values match the fresh frame only.
